lsb_mem_adapter: RTL and testbench

//  Sits between LoadStoreBuffer and MemControl. Accepts one load/store at a time from the LSB.

---
 rtl/lsb_mem_adapter.sv | 117 +++++++++++
 tb/tb_lsb_mem_adapter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsb_mem_adapter.sv
// Bridges one LoadStoreBuffer access at a time onto the MemControl handshake,
// holding the request until completion and returning realigned load data tagged with its ROB id.
module lsb_mem_adapter #(
  parameter int          ROB_W   = 4,
  parameter logic [31:0] IO_ADDR = 32'h30000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             io_buffer_full,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_store,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [ROB_W-1:0] req_rob_id,
  output logic             resp_valid,
  output logic [ROB_W-1:0] resp_rob_id,
  output logic [31:0]      resp_data,
  output logic             mem_req,
  output logic             mem_r_nw,
  output logic [1:0]       mem_work_type,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_busy,
  input  logic             mem_done,
  input  logic [31:0]      mem_rdata
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] IO_WAIT  = 3'd1;
  localparam logic [2:0] ISSUE    = 3'd2;
  localparam logic [2:0] WAIT_MEM = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;

  logic [2:0]       state;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [2:0]       funct3_q;
  logic             is_store_q;
  logic [ROB_W-1:0] rob_id_q;
  logic [31:0]      resp_data_q;
  logic [31:0]      load_ext;

  // MemControl hands back the N loaded bytes in the top N bytes of mem_rdata.
  always_comb begin
    load_ext = mem_rdata;
    case (funct3_q)
      3'b000:  load_ext = {{24{mem_rdata[31]}}, mem_rdata[31:24]};
      3'b001:  load_ext = {{16{mem_rdata[31]}}, mem_rdata[31:16]};
      3'b100:  load_ext = {24'd0, mem_rdata[31:24]};
      3'b101:  load_ext = {16'd0, mem_rdata[31:16]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    mem_work_type = 2'd3;
    case (funct3_q)
      3'b000, 3'b100: mem_work_type = 2'd0;
      3'b001, 3'b101: mem_work_type = 2'd1;
      default:        mem_work_type = 2'd3;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      is_store_q  <= 1'b0;
      rob_id_q    <= '0;
      resp_data_q <= '0;
    end else if (rdy_in) begin
      // A flush wins over everything, including a completion in the same cycle.
      if (clear) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              addr_q     <= req_addr;
              wdata_q    <= req_wdata;
              funct3_q   <= req_funct3;
              is_store_q <= req_is_store;
              rob_id_q   <= req_rob_id;
              state      <= (req_is_store && req_addr == IO_ADDR) ? IO_WAIT : ISSUE;
            end
          end
          IO_WAIT:  if (!io_buffer_full) state <= ISSUE;
          ISSUE:    if (!mem_busy) state <= WAIT_MEM;
          WAIT_MEM: begin
            if (mem_done) begin
              resp_data_q <= is_store_q ? 32'd0 : load_ext;
              state       <= RESP;
            end
          end
          RESP:     state <= IDLE;
          default:  state <= IDLE;
        endcase
      end
    end
  end

  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == RESP);
  assign resp_rob_id = rob_id_q;
  assign resp_data   = resp_data_q;
  assign mem_req     = (state == ISSUE);
  assign mem_r_nw    = is_store_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_lsb_mem_adapter.sv
// Self-checking bench for lsb_mem_adapter: directed scenarios plus random load/store
// traffic against a byte-addressed memory model that stands in for MemControl.
module tb_lsb_mem_adapter;

  localparam logic [31:0] IO_ADDR = 32'h30000;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        io_buffer_full;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_rob_id;
  logic        resp_valid;
  logic [3:0]  resp_rob_id;
  logic [31:0] resp_data;
  logic        mem_req;
  logic        mem_r_nw;
  logic [1:0]  mem_work_type;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_busy;
  logic        mem_done;
  logic [31:0] mem_rdata;

  int testsRun  = 0;
  int failCount = 0;
  logic [31:0] lastRespData;
  logic [7:0]  memModel [int unsigned];

  lsb_mem_adapter #(.ROB_W(4), .IO_ADDR(IO_ADDR)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .io_buffer_full(io_buffer_full), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rob_id(req_rob_id), .resp_valid(resp_valid),
    .resp_rob_id(resp_rob_id), .resp_data(resp_data), .mem_req(mem_req),
    .mem_r_nw(mem_r_nw), .mem_work_type(mem_work_type), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [7:0] memByte(input int unsigned a);
    if (memModel.exists(a)) return memModel[a];
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit isSigned(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001);
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit isStore, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] rob);
    req_valid    = 1'b1;
    req_is_store = isStore;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wdata;
    req_rob_id   = rob;
  endtask

  // Full access as MemControl would see it; expected results come from the byte model.
  task automatic doTransaction(input bit isStore, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] rob,
                               input int ioFull, input int busy, input int waitCyc);
    int n;
    logic [31:0] raw, rdata, expData, mask;
    logic [63:0] m;
    n   = nbytes(f3);
    raw = '0;
    for (int i = 0; i < n; i++) raw[8*i +: 8] = memByte(addr + i);
    m    = (64'd1 << (8*n)) - 64'd1;
    mask = m[31:0];
    rdata = raw << (32 - 8*n);
    if (n < 4) rdata = rdata | ($urandom() & ((32'd1 << (32 - 8*n)) - 32'd1));
    if (isStore) expData = 32'd0;
    else if (isSigned(f3) && raw[8*n-1]) expData = raw | ~mask;
    else expData = raw;

    checkOutput("idle_ready", req_ready, 1);
    io_buffer_full = (ioFull > 0);
    applyStimulus(isStore, f3, addr, wdata, rob);
    tick();
    applyStimulus($urandom_range(0, 1) == 1, 3'($urandom()), $urandom(), $urandom(), 4'($urandom()));
    checkOutput("busy_not_ready", req_ready, 0);
    if (isStore && addr == IO_ADDR) begin
      for (int i = 0; i < ioFull; i++) begin
        checkOutput("io_wait_no_req", mem_req, 0);
        tick();
      end
      io_buffer_full = 1'b0;
      checkOutput("io_wait_no_req", mem_req, 0);
      tick();
    end
    mem_busy = (busy > 0);
    for (int i = 0; i < busy; i++) begin
      checkOutput("issue_hold_req", mem_req, 1);
      checkOutput("issue_hold_addr", mem_addr, addr);
      checkOutput("issue_hold_wdata", mem_wdata, wdata);
      tick();
    end
    mem_busy = 1'b0;
    checkOutput("issue_req", mem_req, 1);
    checkOutput("issue_addr", mem_addr, addr);
    checkOutput("issue_wdata", mem_wdata, wdata);
    checkOutput("issue_r_nw", mem_r_nw, isStore);
    checkOutput("issue_work_type", mem_work_type, n - 1);
    tick();
    checkOutput("wait_no_req", mem_req, 0);
    mem_busy = 1'b1;
    for (int i = 0; i < waitCyc; i++) begin
      checkOutput("wait_no_resp", resp_valid, 0);
      tick();
    end
    mem_done  = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_done  = 1'b0;
    mem_busy  = 1'b0;
    mem_rdata = $urandom();
    req_valid = 1'b0;
    checkOutput("resp_valid", resp_valid, 1);
    checkOutput("resp_rob_id", resp_rob_id, rob);
    checkOutput("resp_data", resp_data, expData);
    lastRespData = resp_data;
    tick();
    checkOutput("resp_pulse_end", resp_valid, 0);
    checkOutput("ready_after_resp", req_ready, 1);
    io_buffer_full = 1'b0;
    if (isStore) for (int i = 0; i < n; i++) memModel[addr + i] = wdata[8*i +: 8];
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0; req_addr = '0;
    req_wdata = '0; req_rob_id = '0; mem_busy = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    repeat (2) tick();
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_resp_data", resp_data, 0);
    checkOutput("rst_work_type", mem_work_type, 0);
    rst_in = 1'b0;
    tick();

    memModel[32'h100] = 8'h78; memModel[32'h101] = 8'h56;
    memModel[32'h102] = 8'h34; memModel[32'h103] = 8'h12;
    memModel[32'h200] = 8'h80;
    memModel[32'h300] = 8'h01; memModel[32'h301] = 8'h80;

    doTransaction(0, 3'b010, 32'h100, 32'h0, 4'd7, 0, 0, 1);
    checkOutput("lw_value", lastRespData, 32'h12345678);
    doTransaction(0, 3'b000, 32'h200, 32'h0, 4'd2, 0, 1, 0);
    checkOutput("lb_value", lastRespData, 32'hFFFFFF80);
    doTransaction(0, 3'b100, 32'h200, 32'h0, 4'd3, 0, 0, 2);
    checkOutput("lbu_value", lastRespData, 32'h00000080);
    doTransaction(0, 3'b001, 32'h300, 32'h0, 4'd4, 0, 0, 0);
    checkOutput("lh_value", lastRespData, 32'hFFFF8001);
    doTransaction(0, 3'b110, 32'h300, 32'h0, 4'd5, 0, 0, 0);
    doTransaction(1, 3'b000, IO_ADDR, 32'h41, 4'd6, 5, 0, 1);
    doTransaction(1, 3'b010, 32'h140, 32'hDEADBEEF, 4'd8, 0, 3, 2);
    checkOutput("sw_resp_zero", lastRespData, 32'h0);

    // Flush in WAIT_MEM together with mem_done: the completion is dropped.
    applyStimulus(0, 3'b010, 32'h100, 32'h0, 4'd9);
    tick(); req_valid = 1'b0;
    tick();
    checkOutput("clr_wait_state", mem_req, 0);
    clear = 1'b1; mem_done = 1'b1; mem_rdata = 32'h12345678;
    tick();
    clear = 1'b0; mem_done = 1'b0;
    checkOutput("clr_done_no_resp", resp_valid, 0);
    checkOutput("clr_done_ready", req_ready, 1);
    tick();
    checkOutput("clr_no_late_resp", resp_valid, 0);

    // Flush in WAIT_MEM, then a stale mem_done while idle must be ignored.
    applyStimulus(0, 3'b010, 32'h100, 32'h0, 4'd10);
    tick(); req_valid = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("clr_wait_ready", req_ready, 1);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    checkOutput("stale_done_no_resp", resp_valid, 0);
    checkOutput("stale_done_ready", req_ready, 1);

    applyStimulus(0, 3'b010, 32'h100, 32'h0, 4'd11);
    tick(); req_valid = 1'b0;
    mem_busy = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; mem_busy = 1'b0;
    checkOutput("clr_issue_no_req", mem_req, 0);
    checkOutput("clr_issue_ready", req_ready, 1);
    doTransaction(0, 3'b010, 32'h100, 32'h0, 4'd12, 0, 0, 0);
    checkOutput("post_clr_lw", lastRespData, 32'h12345678);

    // Global stall during WAIT_MEM and RESP.
    applyStimulus(0, 3'b010, 32'h100, 32'h0, 4'd13);
    tick(); req_valid = 1'b0;
    tick();
    rdy_in = 1'b0; mem_done = 1'b1; mem_rdata = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("stall_wait_resp", resp_valid, 0);
      checkOutput("stall_wait_ready", req_ready, 0);
      checkOutput("stall_wait_req", mem_req, 0);
    end
    rdy_in = 1'b1;
    tick();
    mem_done = 1'b0;
    checkOutput("stall_resp_valid", resp_valid, 1);
    checkOutput("stall_resp_data", resp_data, 32'h12345678);
    rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("stall_resp_hold", resp_valid, 1);
      checkOutput("stall_resp_rob", resp_rob_id, 13);
    end
    rdy_in = 1'b1;
    tick();
    checkOutput("stall_resp_end", resp_valid, 0);
    checkOutput("stall_ready", req_ready, 1);

    rdy_in = 1'b0;
    applyStimulus(0, 3'b010, 32'h100, 32'h0, 4'd14);
    tick(); tick();
    checkOutput("stall_idle_ready", req_ready, 1);
    checkOutput("stall_idle_no_req", mem_req, 0);
    req_valid = 1'b0; rdy_in = 1'b1;
    tick();

    for (int t = 0; t < 24; t++) begin
      bit st;
      logic [2:0] f3;
      st = ($urandom_range(0, 2) == 0);
      f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      doTransaction(st, f3, 32'h180 + $urandom_range(0, 15), $urandom(), 4'($urandom()),
                    0, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
